// File: rtl/des_pkg.sv
// des_pkg: shared constants and FSM state type for the DES Wishbone initiator.
package des_pkg;

    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_DW = 32;

    // Register byte offsets from the DES register file base address
    localparam logic [7:0] DES_KEY_HI_OFF  = 8'h00;
    localparam logic [7:0] DES_KEY_LO_OFF  = 8'h04;
    localparam logic [7:0] DES_DATA_HI_OFF = 8'h08;
    localparam logic [7:0] DES_DATA_LO_OFF = 8'h0C;
    localparam logic [7:0] DES_CTRL_OFF    = 8'h10;
    localparam logic [7:0] DES_STATUS_OFF  = 8'h14;
    localparam logic [7:0] DES_RES_HI_OFF  = 8'h18;
    localparam logic [7:0] DES_RES_LO_OFF  = 8'h1C;

    // CTRL / STATUS bit positions
    localparam int unsigned DES_CTRL_START_BIT   = 0;
    localparam int unsigned DES_CTRL_DECRYPT_BIT = 1;
    localparam int unsigned DES_STATUS_DONE_BIT  = 0;

    typedef enum logic [3:0] {
        IDLE,
        W_KEYH,
        W_KEYL,
        W_DATH,
        W_DATL,
        W_CTRL,
        R_STAT,
        R_RESH,
        R_RESL,
        DONE
    } des_state_e;

endpackage

// File: rtl/wb_single_xfer.sv
// wb_single_xfer: one Wishbone classic single-beat read or write.
// Optional per-beat ack timeout enabled by defining WB_TIMEOUT_EN.
module wb_single_xfer
    import des_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = 8'd64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [WB_AW-1:0] addr,
    input  logic             we,
    input  logic [WB_DW-1:0] wdata,
    output logic             done_c,
    output logic             err_c,
    output logic [WB_DW-1:0] rdata_c,
    output logic             wb_cyc,
    output logic             wb_stb,
    output logic             wb_we,
    output logic [WB_AW-1:0] wb_addr,
    output logic [WB_DW-1:0] wb_data,
    output logic [3:0]       wb_sel,
    input  logic             wb_ack,
    input  logic [WB_DW-1:0] wb_rdata
);

    // An ack only counts while a beat is actually on the bus
    assign done_c  = wb_cyc & wb_ack;
    assign rdata_c = wb_rdata;

`ifdef WB_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    assign err_c = wb_cyc & ~wb_ack & (tmo_cnt == TIMEOUT - 8'd1);

    // Cycles the current beat has waited for ack; zero whenever the bus is idle
    always_ff @(posedge clk) begin
        if (reset || !wb_cyc) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end
`else
    // Without the timeout a beat never aborts; TIMEOUT has no effect here
    assign err_c = 1'b0 && (TIMEOUT != 8'd0);
`endif

    // Launch a beat on req from idle, drop cyc/stb on the edge after ack or abort
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_cyc  <= 1'b0;
            wb_stb  <= 1'b0;
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            wb_sel  <= 4'h0;
        end else if (!wb_cyc) begin
            if (req) begin
                wb_cyc  <= 1'b1;
                wb_stb  <= 1'b1;
                wb_we   <= we;
                wb_addr <= addr;
                wb_data <= wdata;
                wb_sel  <= 4'hF;
            end
        end else if (done_c || err_c) begin
            wb_cyc  <= 1'b0;
            wb_stb  <= 1'b0;
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            wb_sel  <= 4'h0;
        end
    end

endmodule

// File: rtl/des_wb_master.sv
// des_wb_master: runs one DES block operation over Wishbone (key, data,
// ctrl writes, status polling, result readback). Define WB_TIMEOUT_EN to
// abort a transfer that waits TIMEOUT cycles without ack.
module des_wb_master
    import des_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [15:0] POLL_MAX  = 16'd1024,
    parameter logic [7:0]  TIMEOUT   = 8'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [63:0] i_key,
    input  logic [63:0] i_data,
    input  logic        i_decrypt,
    output logic        o_busy,
    output logic        o_valid,
    output logic [63:0] o_result,
    output logic        o_error,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data
);

    des_state_e       state;
    logic [63:0]      key_q;
    logic [63:0]      data_q;
    logic             decrypt_q;
    logic [15:0]      poll_cnt;
    logic             xfer_req;

    logic [7:0]       xfer_off_c;
    logic             xfer_we_c;
    logic [WB_DW-1:0] xfer_wdata_c;
    logic [WB_AW-1:0] xfer_addr_c;
    logic             xfer_done_c;
    logic             xfer_err_c;
    logic [WB_DW-1:0] xfer_rdata_c;

    // Transfer descriptor for the current bus state
    always_comb begin
        xfer_off_c   = DES_KEY_HI_OFF;
        xfer_we_c    = 1'b0;
        xfer_wdata_c = '0;
        case (state)
            W_KEYH: begin
                xfer_off_c   = DES_KEY_HI_OFF;
                xfer_we_c    = 1'b1;
                xfer_wdata_c = key_q[63:32];
            end
            W_KEYL: begin
                xfer_off_c   = DES_KEY_LO_OFF;
                xfer_we_c    = 1'b1;
                xfer_wdata_c = key_q[31:0];
            end
            W_DATH: begin
                xfer_off_c   = DES_DATA_HI_OFF;
                xfer_we_c    = 1'b1;
                xfer_wdata_c = data_q[63:32];
            end
            W_DATL: begin
                xfer_off_c   = DES_DATA_LO_OFF;
                xfer_we_c    = 1'b1;
                xfer_wdata_c = data_q[31:0];
            end
            W_CTRL: begin
                xfer_off_c                         = DES_CTRL_OFF;
                xfer_we_c                          = 1'b1;
                xfer_wdata_c[DES_CTRL_START_BIT]   = 1'b1;
                xfer_wdata_c[DES_CTRL_DECRYPT_BIT] = decrypt_q;
            end
            R_STAT: xfer_off_c = DES_STATUS_OFF;
            R_RESH: xfer_off_c = DES_RES_HI_OFF;
            R_RESL: xfer_off_c = DES_RES_LO_OFF;
            default: xfer_off_c = DES_KEY_HI_OFF;
        endcase
    end

    assign xfer_addr_c = BASE_ADDR + WB_AW'(xfer_off_c);

    // Job sequencing: each completed beat advances the state and requests the next
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            key_q     <= '0;
            data_q    <= '0;
            decrypt_q <= 1'b0;
            poll_cnt  <= '0;
            xfer_req  <= 1'b0;
            o_busy    <= 1'b0;
            o_valid   <= 1'b0;
            o_error   <= 1'b0;
            o_result  <= '0;
        end else begin
            xfer_req <= 1'b0;
            o_valid  <= 1'b0;
            o_error  <= 1'b0;
            if (xfer_err_c) begin
                state   <= IDLE;
                o_busy  <= 1'b0;
                o_error <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (i_start) begin
                        key_q     <= i_key;
                        data_q    <= i_data;
                        decrypt_q <= i_decrypt;
                        poll_cnt  <= '0;
                        o_busy    <= 1'b1;
                        xfer_req  <= 1'b1;
                        state     <= W_KEYH;
                    end
                    W_KEYH: if (xfer_done_c) begin
                        xfer_req <= 1'b1;
                        state    <= W_KEYL;
                    end
                    W_KEYL: if (xfer_done_c) begin
                        xfer_req <= 1'b1;
                        state    <= W_DATH;
                    end
                    W_DATH: if (xfer_done_c) begin
                        xfer_req <= 1'b1;
                        state    <= W_DATL;
                    end
                    W_DATL: if (xfer_done_c) begin
                        xfer_req <= 1'b1;
                        state    <= W_CTRL;
                    end
                    W_CTRL: if (xfer_done_c) begin
                        poll_cnt <= '0;
                        xfer_req <= 1'b1;
                        state    <= R_STAT;
                    end
                    R_STAT: if (xfer_done_c) begin
                        if (xfer_rdata_c[DES_STATUS_DONE_BIT]) begin
                            xfer_req <= 1'b1;
                            state    <= R_RESH;
                        end else if (poll_cnt + 16'd1 == POLL_MAX) begin
                            poll_cnt <= poll_cnt + 16'd1;
                            o_error  <= 1'b1;
                            o_busy   <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            poll_cnt <= poll_cnt + 16'd1;
                            xfer_req <= 1'b1;
                        end
                    end
                    R_RESH: if (xfer_done_c) begin
                        o_result[63:32] <= xfer_rdata_c;
                        xfer_req        <= 1'b1;
                        state           <= R_RESL;
                    end
                    R_RESL: if (xfer_done_c) begin
                        o_result[31:0] <= xfer_rdata_c;
                        state          <= DONE;
                    end
                    DONE: begin
                        o_valid <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    wb_single_xfer #(
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .clk      (clk),
        .reset    (reset),
        .req      (xfer_req),
        .addr     (xfer_addr_c),
        .we       (xfer_we_c),
        .wdata    (xfer_wdata_c),
        .done_c   (xfer_done_c),
        .err_c    (xfer_err_c),
        .rdata_c  (xfer_rdata_c),
        .wb_cyc   (o_wb_cyc),
        .wb_stb   (o_wb_stb),
        .wb_we    (o_wb_we),
        .wb_addr  (o_wb_addr),
        .wb_data  (o_wb_data),
        .wb_sel   (o_wb_sel),
        .wb_ack   (i_wb_ack),
        .wb_rdata (i_wb_data)
    );

endmodule

// File: tb/tb_des_wb_master.sv
// tb_des_wb_master: directed bench for des_wb_master against a DES register-file slave model.
module tb_des_wb_master;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [63:0] KEY  = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] KEY2 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] PT   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] CT   = 64'h85E8_1354_0F0A_B405;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic [63:0] i_key = 64'h0;
    logic [63:0] i_data = 64'h0;
    logic        i_decrypt = 1'b0;
    logic        o_busy, o_valid, o_error;
    logic [63:0] o_result;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_addr, o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_ack;
    logic [31:0] i_wb_data;

    // Slave model state
    logic        s_ack = 1'b0;
    logic        stray_ack = 1'b0;
    logic        no_ack = 1'b0;
    logic        never_done = 1'b0;
    logic [31:0] s_rdata = 32'h0;
    logic [63:0] s_key = 64'h0;
    logic [63:0] s_data = 64'h0;
    logic [63:0] s_res = 64'h0;
    logic [31:0] ctrl_wr = 32'h0;
    logic [31:0] last_keyh = 32'h0;
    int          stat_left = 0;
    int          n_writes = 0;
    int          n_keyh = 0;
    int          n_stat = 0;
    int          bad_sel = 0;

    // Monitor counters
    int   n_valid = 0;
    int   n_error = 0;
    int   n_both = 0;
    int   gap_err = 0;
    logic ack_d = 1'b0;

    int n_assert = 0;
    int n_fail = 0;

    assign i_wb_ack  = s_ack | stray_ack;
    assign i_wb_data = s_rdata;

    always #5 clk = ~clk;

    des_wb_master #(
        .BASE_ADDR (BASE),
        .POLL_MAX  (16'd4),
        .TIMEOUT   (8'd64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_start   (i_start),
        .i_key     (i_key),
        .i_data    (i_data),
        .i_decrypt (i_decrypt),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .o_result  (o_result),
        .o_error   (o_error),
        .o_wb_cyc  (o_wb_cyc),
        .o_wb_stb  (o_wb_stb),
        .o_wb_we   (o_wb_we),
        .o_wb_addr (o_wb_addr),
        .o_wb_data (o_wb_data),
        .o_wb_sel  (o_wb_sel),
        .i_wb_ack  (i_wb_ack),
        .i_wb_data (i_wb_data)
    );

    // Known-answer stand-in for the DES core
    function automatic logic [63:0] des_lookup(input logic [63:0] k, input logic [63:0] d,
                                               input logic dec);
        if (k == KEY && !dec && d == PT) return CT;
        if (k == KEY && dec && d == CT) return PT;
        return 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    // Slave: registered ack one cycle after stb, done after two zero STATUS reads
    always @(posedge clk) begin
        s_ack <= 1'b0;
        if (o_wb_cyc && o_wb_stb && !s_ack && !no_ack) begin
            s_ack <= 1'b1;
            if (o_wb_sel != 4'hF) bad_sel <= bad_sel + 1;
            if (o_wb_we) begin
                n_writes <= n_writes + 1;
                case (o_wb_addr)
                    BASE + 32'h00: begin
                        s_key[63:32] <= o_wb_data;
                        last_keyh    <= o_wb_data;
                        n_keyh       <= n_keyh + 1;
                    end
                    BASE + 32'h04: s_key[31:0]   <= o_wb_data;
                    BASE + 32'h08: s_data[63:32] <= o_wb_data;
                    BASE + 32'h0C: s_data[31:0]  <= o_wb_data;
                    BASE + 32'h10: begin
                        ctrl_wr   <= o_wb_data;
                        stat_left <= 2;
                        s_res     <= des_lookup(s_key, s_data, o_wb_data[1]);
                    end
                    default: ;
                endcase
            end else begin
                case (o_wb_addr)
                    BASE + 32'h14: begin
                        n_stat  <= n_stat + 1;
                        s_rdata <= (stat_left == 0 && !never_done) ? 32'h1 : 32'h0;
                        if (stat_left != 0) stat_left <= stat_left - 1;
                    end
                    BASE + 32'h18: s_rdata <= s_res[63:32];
                    BASE + 32'h1C: s_rdata <= s_res[31:0];
                    default:       s_rdata <= 32'hFFFF_FFFF;
                endcase
            end
        end
    end

    // Strobe counters and inter-transfer gap monitor
    always @(negedge clk) begin
        if (o_valid) n_valid <= n_valid + 1;
        if (o_error) n_error <= n_error + 1;
        if (o_valid && o_error) n_both <= n_both + 1;
        if (ack_d && o_wb_cyc) gap_err <= gap_err + 1;
        ack_d <= o_wb_cyc && i_wb_ack;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [63:0] k, input logic [63:0] d, input logic dec);
        i_key     = k;
        i_data    = d;
        i_decrypt = dec;
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
    endtask

    task automatic wait_end(input int max_cycles, output logic gv, output logic ge);
        gv = 1'b0;
        ge = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (o_valid || o_error) begin
                gv = o_valid;
                ge = o_error;
                return;
            end
        end
    endtask

    initial begin
        logic gv, ge, found;
        int v0, e0, s0, w0, k0, cnt;

        // Reset state
        tick();
        tick();
        check("rst_cyc", 64'(o_wb_cyc), 64'd0);
        check("rst_stb", 64'(o_wb_stb), 64'd0);
        check("rst_sel", 64'(o_wb_sel), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_strobes", 64'({o_valid, o_error}), 64'd0);
        check("rst_result", o_result, 64'd0);
        reset = 1'b0;
        tick();

        // Encrypt known answer
        v0 = n_valid; e0 = n_error; s0 = n_stat; w0 = n_writes;
        start_job(KEY, PT, 1'b0);
        check("enc_busy_after_accept", 64'(o_busy), 64'd1);
        wait_end(400, gv, ge);
        check("enc_valid", 64'(gv), 64'd1);
        check("enc_busy_falls", 64'(o_busy), 64'd0);
        check("enc_result", o_result, CT);
        tick();
        check("enc_valid_one_cycle", 64'(o_valid), 64'd0);
        check("enc_result_held", o_result, CT);
        check("enc_writes", 64'(n_writes - w0), 64'd5);
        check("enc_ctrl", 64'(ctrl_wr), 64'h1);
        check("enc_stat_reads", 64'(n_stat - s0), 64'd3);
        check("enc_valid_count", 64'(n_valid - v0), 64'd1);
        check("enc_no_error", 64'(n_error - e0), 64'd0);

        // Decrypt known answer
        v0 = n_valid;
        start_job(KEY, CT, 1'b1);
        wait_end(400, gv, ge);
        check("dec_valid", 64'(gv), 64'd1);
        check("dec_result", o_result, PT);
        tick();
        check("dec_ctrl", 64'(ctrl_wr), 64'h3);
        check("dec_valid_count", 64'(n_valid - v0), 64'd1);

        // Status never done: abandoned after POLL_MAX reads
        never_done = 1'b1;
        v0 = n_valid; e0 = n_error; s0 = n_stat;
        start_job(KEY, PT, 1'b0);
        wait_end(400, gv, ge);
        check("poll_error", 64'(ge), 64'd1);
        check("poll_no_valid", 64'(gv), 64'd0);
        check("poll_busy_low", 64'(o_busy), 64'd0);
        tick();
        check("poll_error_one_cycle", 64'(o_error), 64'd0);
        check("poll_stat_reads", 64'(n_stat - s0), 64'd4);
        check("poll_error_count", 64'(n_error - e0), 64'd1);
        check("poll_valid_count", 64'(n_valid - v0), 64'd0);
        never_done = 1'b0;

        // Second start while busy is ignored
        v0 = n_valid; k0 = n_keyh;
        start_job(KEY, PT, 1'b0);
        tick();
        tick();
        start_job(KEY2, CT, 1'b1);
        wait_end(400, gv, ge);
        check("busy_valid", 64'(gv), 64'd1);
        check("busy_result", o_result, CT);
        repeat (40) tick();
        check("busy_keyh_writes", 64'(n_keyh - k0), 64'd1);
        check("busy_keyh_value", 64'(last_keyh), 64'(KEY[63:32]));
        check("busy_valid_count", 64'(n_valid - v0), 64'd1);
        check("busy_idle_after", 64'(o_busy), 64'd0);

        // Ack while the bus is idle is ignored
        v0 = n_valid; e0 = n_error;
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        tick();
        check("stray_cyc", 64'(o_wb_cyc), 64'd0);
        check("stray_busy", 64'(o_busy), 64'd0);
        check("stray_strobes", 64'((n_valid - v0) + (n_error - e0)), 64'd0);

        // Reset during the DATA_HI write, then a clean job
        v0 = n_valid; e0 = n_error;
        start_job(KEY, PT, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (o_wb_cyc && o_wb_addr == BASE + 32'h08) found = 1'b1;
            else tick();
        end
        check("rst_reach_dath", 64'(found), 64'd1);
        reset = 1'b1;
        tick();
        check("rst_mid_cyc", 64'(o_wb_cyc), 64'd0);
        check("rst_mid_stb", 64'(o_wb_stb), 64'd0);
        check("rst_mid_busy", 64'(o_busy), 64'd0);
        reset = 1'b0;
        repeat (5) tick();
        check("rst_mid_no_strobes", 64'((n_valid - v0) + (n_error - e0)), 64'd0);
        start_job(KEY, PT, 1'b0);
        wait_end(400, gv, ge);
        check("rst_fresh_valid", 64'(gv), 64'd1);
        check("rst_fresh_result", o_result, CT);

`ifdef WB_TIMEOUT_EN
        // No ack for KEY_HI: beat aborts after TIMEOUT cycles
        no_ack = 1'b1;
        e0 = n_error;
        cnt = 0;
        start_job(KEY, PT, 1'b0);
        gv = 1'b0;
        ge = 1'b0;
        for (int i = 0; i < 200 && !ge; i++) begin
            tick();
            if (o_error) ge = 1'b1;
            else if (o_wb_cyc) cnt++;
        end
        check("tmo_error", 64'(ge), 64'd1);
        check("tmo_cyc_cycles", 64'(cnt), 64'd64);
        check("tmo_cyc_dropped", 64'(o_wb_cyc), 64'd0);
        no_ack = 1'b0;
        tick();
        check("tmo_error_one_cycle", 64'(o_error), 64'd0);
        check("tmo_error_count", 64'(n_error - e0), 64'd1);
`endif

        // Bus-protocol invariants across the run
        tick();
        check("never_valid_and_error", 64'(n_both), 64'd0);
        check("idle_gap_between_beats", 64'(gap_err), 64'd0);
        check("sel_full_word", 64'(bad_sel), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
